// File: rtl/fifo_feeder_pkg.sv
// Shared definitions for the FIFO read-side to UART TX feeder.
//   feeder_state_e : controller state encoding (3 bits)
//   MIN_GAP        : smallest inter-frame gap the read pointer needs to settle
//   FRAME_CNT_W    : width of the optional frame counter
//   max_int()      : elaboration-time helper for sizing the timers
package fifo_feeder_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } feeder_state_e;

  localparam int MIN_GAP     = 2;
  localparam int FRAME_CNT_W = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/feeder_timer.sv
// Loadable down-counter used by the feeder for its busy timeout and
// inter-frame gap.
//   r_clk, r_rst_n : clock, asynchronous active-low reset
//   load, load_val : load the count (has priority over dec)
//   dec            : decrement by one, stopping at 0 (never wraps)
//   zero           : high when this decrement brings the count to 0
//                    (count is 1) or the count already sits at 0
module feeder_timer #(
  parameter int W = 5
) (
  input  logic         r_clk,
  input  logic         r_rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // Looking one step ahead lets the owner leave its state on the cycle the
  // count reaches 0, so a load of N spans exactly N cycles.
  assign zero = (count[W-1:1] == '0);

endmodule

// File: rtl/fifo_rd_tx_feeder.sv
// Read-domain controller that drains the async FIFO into the UART
// transmitter: pops one word, pulses tx_data_valid, follows tx_busy through
// the frame, then idles for a gap so the FIFO's registered gray read pointer
// settles before r_empty is sampled again. A frame that the UART does not
// pick up within BUSY_TO cycles is re-offered with the same word.
//   r_clk, r_rst_n : clock, asynchronous active-low reset
//   en             : feeder enable, sampled only in IDLE
//   r_empty,r_data : FIFO read side
//   tx_busy        : UART TX busy
//   r_inc          : registered single-cycle FIFO pop
//   tx_data        : registered frame payload, held between frames
//   tx_data_valid  : registered single-cycle start pulse to UART TX
// Optional (macro FEEDER_FRAME_CNT_EN):
//   frame_cnt      : saturating count of completed frames
//   retry_flag     : sticky, set on any busy timeout
module fifo_rd_tx_feeder
  import fifo_feeder_pkg::*;
#(
  parameter int D_WIDTH    = 8,
  parameter int GAP_CYCLES = 2,
  parameter int BUSY_TO    = 16
) (
  input  logic               r_clk,
  input  logic               r_rst_n,
  input  logic               en,
  input  logic               r_empty,
  input  logic [D_WIDTH-1:0] r_data,
  input  logic               tx_busy,
  output logic               r_inc,
  output logic [D_WIDTH-1:0] tx_data,
  output logic               tx_data_valid
`ifdef FEEDER_FRAME_CNT_EN
  ,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   retry_flag
`endif
);

  localparam int GAP_LOAD = (GAP_CYCLES < MIN_GAP) ? MIN_GAP : GAP_CYCLES;
  localparam int TMR_W    = $clog2(max_int(BUSY_TO, GAP_LOAD) + 1);
  localparam logic [TMR_W-1:0] BUSY_VAL = TMR_W'(BUSY_TO);
  localparam logic [TMR_W-1:0] GAP_VAL  = TMR_W'(GAP_LOAD);

  feeder_state_e state, state_next;
  logic pop, valid_next;
  logic to_load, to_dec, to_zero;
  logic gap_load, gap_dec, gap_zero;

  feeder_timer #(.W(TMR_W)) u_busy_timer (
    .r_clk    (r_clk),
    .r_rst_n  (r_rst_n),
    .load     (to_load),
    .load_val (BUSY_VAL),
    .dec      (to_dec),
    .zero     (to_zero)
  );

  feeder_timer #(.W(TMR_W)) u_gap_timer (
    .r_clk    (r_clk),
    .r_rst_n  (r_rst_n),
    .load     (gap_load),
    .load_val (GAP_VAL),
    .dec      (gap_dec),
    .zero     (gap_zero)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    valid_next = 1'b0;
    to_load    = 1'b0;
    to_dec     = 1'b0;
    gap_load   = 1'b0;
    gap_dec    = 1'b0;
    case (state)
      IDLE: begin
        if (en && !r_empty) begin
          pop        = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        valid_next = 1'b1;
        to_load    = 1'b1;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        to_dec = 1'b1;
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end else if (to_zero) begin
          // Re-offer the same word; the FIFO has already been popped.
          state_next = SEND;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          gap_load   = 1'b1;
          state_next = GAP;
        end
      end
      GAP: begin
        gap_dec = 1'b1;
        if (gap_zero) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      state         <= IDLE;
      r_inc         <= 1'b0;
      tx_data_valid <= 1'b0;
      tx_data       <= '0;
    end else begin
      state         <= state_next;
      r_inc         <= pop;
      tx_data_valid <= valid_next;
      if (pop) begin
        tx_data <= r_data;
      end
    end
  end

`ifdef FEEDER_FRAME_CNT_EN
  logic frame_done, busy_timeout;

  assign frame_done   = (state == WAIT_DONE) && !tx_busy;
  assign busy_timeout = (state == WAIT_BUSY) && !tx_busy && to_zero;

  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      frame_cnt  <= '0;
      retry_flag <= 1'b0;
    end else begin
      if (frame_done && (frame_cnt != '1)) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
      if (busy_timeout) begin
        retry_flag <= 1'b1;
      end
    end
  end
`endif

endmodule
